nibble_demux_writer: RTL and testbench
======================================

Name: nibble_demux_writer

Overview:
- Write-side counterpart of the registered 4-way nibble selector.
- Takes a stream of 4-bit data beats with a 3-bit address over a valid/ready handshake and distributes them into four registered 4-bit outputs b0..b3.
- Supports single addressed writes, clear-all and set-all commands, and a 4-beat burst that fills b0..b3 in order.
- Its outputs feed the selector's b0..b3 inputs directly.

Parameters:
DW, 4, data width of each beat and of each output register
BURST_LEN, 4, beats per burst; fixed equal to the number of output registers, not to be overridden

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  beat present on a/d/burst
in_ready  output  1  block can accept a beat this cycle
a  input  3  command/address code, sampled on handshake
d  input  DW  data beat
burst  input  1  start a 4-beat burst, sampled only on an accepted beat in IDLE
b0  output  DW  register 0
b1  output  DW  register 1
b2  output  DW  register 2
b3  output  DW  register 3
wr_strobe  output  4  one-hot/all-ones pulse marking which b registers changed this cycle
busy  output  1  burst in progress (BURST or DONE)
done  output  1  one-cycle pulse after the last burst beat is written

Behaviour:
- Reset (reset_n low, async):
  - b0..b3 = 0, wr_strobe = 0, busy = 0, done = 0, state = IDLE, idx = 0.
  - in_ready = 0 while reset_n is low.
  - Reset mid-burst abandons the burst; no done pulse.
- Handshake:
  - A beat is accepted when in_valid && in_ready at a rising clk edge.
  - in_ready is combinational from state: 1 in IDLE and BURST, 0 in DONE.
- Latency: 1 cycle. On the edge that accepts a beat, the target b register(s) update. wr_strobe is registered and asserts in the same cycle the new b values are visible, for exactly 1 cycle.
- wr_strobe is 0 in any cycle following an edge with no accepted beat.
- IDLE, accepted beat with burst = 0, decode a:
  - 000/001/010/011: b[a] <= d; wr_strobe = one-hot bit a; other b hold.
  - 100: b0..b3 <= 0; wr_strobe = 1111.
  - 101/110/111: b0..b3 <= all-ones; wr_strobe = 1111.
  - State stays IDLE.
- IDLE, accepted beat with burst = 1:
  - a is ignored.
  - b0 <= d; wr_strobe = 0001; idx <= 1; state <= BURST; busy <= 1.
- BURST:
  - Each accepted beat: b[idx] <= d; wr_strobe = one-hot idx; idx <= idx + 1.
  - a and burst are ignored.
  - No accepted beat: hold everything (stalls allowed indefinitely).
  - Accepted beat with idx = 3: write b3, state <= DONE.
- DONE:
  - Lasts exactly 1 cycle: done = 1, busy = 1, in_ready = 0.
  - Then state <= IDLE, busy <= 0, done <= 0.
- busy: registered, 1 from the cycle after the first burst beat through the DONE cycle inclusive.
- idx: 2-bit, only meaningful in BURST; reset to 0 on entering IDLE.
- Simultaneous events: in_valid held high across DONE is not accepted in DONE; the beat is taken the following IDLE cycle.
- No illegal states: any unreachable encoding returns to IDLE with outputs unchanged.

Decomposition:
- Shared package (nibble_pkg):
  - Command code constants: CMD_B0..CMD_B3 = 000..011, CMD_CLR = 100, set-all = 101..111.
  - State enum IDLE/BURST/DONE.
  - DW default.
- One natural sub-module: nibble_addr_decode (combinational). Maps a and burst-mode idx to the 4-bit write-enable vector and a clear/set flag; reused by the bench as a reference model.

Test Plan:
- Reset and single write: reset_n low, then write a=010 d=0x9 -> next cycle b2=0x9, wr_strobe=0100, b0/b1/b3=0, busy=0.
- Clear and set commands: fill b0..b3 = 0x1,0x2,0x3,0x4, then a=101 -> all 0xF with wr_strobe=1111; then a=100 -> all 0x0 with wr_strobe=1111.
- Burst with stalls: burst=1 d=0xA, then d=0xB, idle 3 cycles, then 0xC, 0xD -> b0..b3 = A,B,C,D; wr_strobe walks 0001/0010/0100/1000; done=1 for one cycle after the 0xD write; in_ready=0 in that cycle.
- Back-to-back with in_valid held high: burst of 4 then a=000 d=0x5 presented continuously -> the single write is accepted only after DONE; b0=0x5 two cycles after the last burst beat.
- Burst ignores a/burst: during BURST drive a=100 and burst=1 -> data still lands in b[idx]; no clear occurs.
- Reset mid-burst: assert reset_n low after 2 burst beats -> all b=0, busy=0, no done pulse; after release, in_ready=1 in IDLE.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble demux writer: command codes, FSM states, widths.
package nibble_pkg;

    localparam int DW_DEF    = 4;
    localparam int NUM_REGS  = 4;

    // Command codes on a[2:0]; 101, 110 and 111 all mean set-all
    localparam logic [2:0] CMD_B0  = 3'b000;
    localparam logic [2:0] CMD_B1  = 3'b001;
    localparam logic [2:0] CMD_B2  = 3'b010;
    localparam logic [2:0] CMD_B3  = 3'b011;
    localparam logic [2:0] CMD_CLR = 3'b100;
    localparam logic [2:0] CMD_SET = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/nibble_addr_decode.sv
// Combinational decode of command/address (or burst index) into per-register
// write enables plus clear/set flags.
module nibble_addr_decode
    import nibble_pkg::*;
(
    input  logic [2:0] a,
    input  logic       burst_mode,
    input  logic [1:0] idx,
    output logic [3:0] we,
    output logic       clr,
    output logic       set
);

    // In burst mode the command code is ignored and idx selects the register
    always_comb begin
        we  = '0;
        clr = 1'b0;
        set = 1'b0;
        if (burst_mode) begin
            we[idx] = 1'b1;
        end else begin
            case (a)
                CMD_B0, CMD_B1, CMD_B2, CMD_B3: we[a[1:0]] = 1'b1;
                CMD_CLR: begin
                    we  = '1;
                    clr = 1'b1;
                end
                default: begin
                    we  = '1;
                    set = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/nibble_demux_writer.sv
// Distributes a valid/ready stream of nibble beats into four registered
// outputs b0..b3: addressed writes, clear-all, set-all, and 4-beat bursts.
module nibble_demux_writer
    import nibble_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int BURST_LEN = NUM_REGS   // tied to the register count; leave at 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    a,
    input  logic [DW-1:0] d,
    input  logic          burst,
    output logic [DW-1:0] b0,
    output logic [DW-1:0] b1,
    output logic [DW-1:0] b2,
    output logic [DW-1:0] b3,
    output logic [3:0]    wr_strobe,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] LAST_IDX = 2'(BURST_LEN - 1);

    state_t                         state;
    logic   [1:0]                   idx;
    logic   [NUM_REGS-1:0][DW-1:0]  breg;

    logic          acc;
    logic [3:0]    we;
    logic          clr, set;
    logic [DW-1:0] wdata;

    // Ready only in states that take beats; held low through reset
    assign in_ready = reset_n && (state == ST_IDLE || state == ST_BURST);
    assign acc      = in_valid && in_ready;

    // A burst beat is either the opening beat in IDLE or any beat in BURST;
    // idx is 0 in IDLE so the opening beat lands in b0.
    nibble_addr_decode u_dec (
        .a          (a),
        .burst_mode (burst || state == ST_BURST),
        .idx        (idx),
        .we         (we),
        .clr        (clr),
        .set        (set)
    );

    // Payload for the enabled registers
    always_comb begin
        wdata = d;
        if (state == ST_IDLE && !burst) begin
            if (clr)      wdata = '0;
            else if (set) wdata = '1;
        end
    end

    // Control FSM with registered data, strobe and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            breg      <= '0;
            wr_strobe <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wr_strobe <= '0;
            case (state)
                ST_IDLE: begin
                    if (acc) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (we[i]) breg[i] <= wdata;
                        wr_strobe <= we;
                        if (burst) begin
                            idx   <= 2'd1;
                            state <= ST_BURST;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    if (acc) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (we[i]) breg[i] <= wdata;
                        wr_strobe <= we;
                        idx       <= idx + 2'd1;
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: recover to IDLE, data registers untouched
                    state <= ST_IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign b0 = breg[0];
    assign b1 = breg[1];
    assign b2 = breg[2];
    assign b3 = breg[3];

endmodule

// File: tb/tb_nibble_demux_writer.sv
// Directed bench for nibble_demux_writer with hand-computed expectations.
module tb_nibble_demux_writer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] a;
    logic [3:0] d;
    logic       burst;
    logic [3:0] b0, b1, b2, b3;
    logic [3:0] wr_strobe;
    logic       busy, done;
    logic [15:0] bv;

    int errors = 0;
    int checks = 0;

    assign bv = {b3, b2, b1, b0};

    always #5 clk = ~clk;

    nibble_demux_writer #(.DW(4), .BURST_LEN(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .d         (d),
        .burst     (burst),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .b3        (b3),
        .wr_strobe (wr_strobe),
        .busy      (busy),
        .done      (done)
    );

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one edge, then drop valid
    task automatic beat(input logic [2:0] aa, input logic [3:0] dd, input logic bb);
        a = aa; d = dd; burst = bb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; burst = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; a = '0; d = '0; burst = 1'b0;
        tick(); tick();
        checks++;
        if ({bv, wr_strobe, busy, done} !== 26'h0) begin
            errors++; $display("FAIL reset_state got b=%h strb=%b busy=%b done=%b exp all 0", bv, wr_strobe, busy, done);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b exp=0", in_ready);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_single();
        beat(3'b010, 4'h9, 1'b0);
        checks++;
        if (bv !== 16'h0900 || wr_strobe !== 4'b0100 || busy !== 1'b0) begin
            errors++; $display("FAIL single_write got b=%h strb=%b busy=%b exp b=0900 strb=0100 busy=0", bv, wr_strobe, busy);
        end
        tick();
        checks++;
        if (wr_strobe !== 4'b0000 || bv !== 16'h0900) begin
            errors++; $display("FAIL strobe_clear got b=%h strb=%b exp b=0900 strb=0000", bv, wr_strobe);
        end
    endtask

    task automatic test_clr_set();
        beat(3'b000, 4'h1, 1'b0);
        beat(3'b001, 4'h2, 1'b0);
        beat(3'b010, 4'h3, 1'b0);
        beat(3'b011, 4'h4, 1'b0);
        checks++;
        if (bv !== 16'h4321 || wr_strobe !== 4'b1000) begin
            errors++; $display("FAIL fill got b=%h strb=%b exp b=4321 strb=1000", bv, wr_strobe);
        end
        beat(3'b101, 4'h7, 1'b0);
        checks++;
        if (bv !== 16'hFFFF || wr_strobe !== 4'b1111) begin
            errors++; $display("FAIL set_101 got b=%h strb=%b exp b=ffff strb=1111", bv, wr_strobe);
        end
        beat(3'b100, 4'h7, 1'b0);
        checks++;
        if (bv !== 16'h0000 || wr_strobe !== 4'b1111) begin
            errors++; $display("FAIL clr_100 got b=%h strb=%b exp b=0000 strb=1111", bv, wr_strobe);
        end
        beat(3'b111, 4'h2, 1'b0);
        checks++;
        if (bv !== 16'hFFFF || wr_strobe !== 4'b1111 || busy !== 1'b0) begin
            errors++; $display("FAIL set_111 got b=%h strb=%b busy=%b exp b=ffff strb=1111 busy=0", bv, wr_strobe, busy);
        end
        beat(3'b100, 4'h0, 1'b0);
    endtask

    task automatic test_burst_stall();
        beat(3'b011, 4'hA, 1'b1);
        checks++;
        if (bv !== 16'h000A || wr_strobe !== 4'b0001 || busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL burst_b0 got b=%h strb=%b busy=%b rdy=%b exp b=000a strb=0001 busy=1 rdy=1", bv, wr_strobe, busy, in_ready);
        end
        beat(3'b000, 4'hB, 1'b0);
        checks++;
        if (bv !== 16'h00BA || wr_strobe !== 4'b0010) begin
            errors++; $display("FAIL burst_b1 got b=%h strb=%b exp b=00ba strb=0010", bv, wr_strobe);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bv !== 16'h00BA || wr_strobe !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL burst_stall%0d got b=%h strb=%b busy=%b done=%b exp b=00ba strb=0000 busy=1 done=0", i, bv, wr_strobe, busy, done);
            end
        end
        beat(3'b000, 4'hC, 1'b0);
        checks++;
        if (bv !== 16'h0CBA || wr_strobe !== 4'b0100 || done !== 1'b0) begin
            errors++; $display("FAIL burst_b2 got b=%h strb=%b done=%b exp b=0cba strb=0100 done=0", bv, wr_strobe, done);
        end
        beat(3'b000, 4'hD, 1'b0);
        checks++;
        if (bv !== 16'hDCBA || wr_strobe !== 4'b1000 || done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL burst_done got b=%h strb=%b done=%b busy=%b rdy=%b exp b=dcba strb=1000 done=1 busy=1 rdy=0", bv, wr_strobe, done, busy, in_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || wr_strobe !== 4'b0000) begin
            errors++; $display("FAIL burst_exit got done=%b busy=%b rdy=%b strb=%b exp 0 0 1 0000", done, busy, in_ready, wr_strobe);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; a = 3'b000;
        burst = 1'b1; d = 4'h1; tick();
        burst = 1'b0; d = 4'h2; tick();
        d = 4'h3; tick();
        d = 4'h4; tick();
        checks++;
        if (bv !== 16'h4321 || done !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_last got b=%h done=%b rdy=%b exp b=4321 done=1 rdy=0", bv, done, in_ready);
        end
        a = 3'b000; d = 4'h5;
        tick();
        checks++;
        if (bv !== 16'h4321 || wr_strobe !== 4'b0000 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_done_hold got b=%h strb=%b done=%b busy=%b exp b=4321 strb=0000 done=0 busy=0", bv, wr_strobe, done, busy);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (bv !== 16'h4325 || wr_strobe !== 4'b0001 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_single got b=%h strb=%b busy=%b exp b=4325 strb=0001 busy=0", bv, wr_strobe, busy);
        end
    endtask

    task automatic test_burst_ignores();
        beat(3'b100, 4'h6, 1'b1);
        beat(3'b100, 4'h7, 1'b1);
        checks++;
        if (bv !== 16'h4376 || wr_strobe !== 4'b0010) begin
            errors++; $display("FAIL ign_clr got b=%h strb=%b exp b=4376 strb=0010", bv, wr_strobe);
        end
        beat(3'b101, 4'h8, 1'b1);
        beat(3'b100, 4'h9, 1'b1);
        checks++;
        if (bv !== 16'h9876 || wr_strobe !== 4'b1000 || done !== 1'b1) begin
            errors++; $display("FAIL ign_done got b=%h strb=%b done=%b exp b=9876 strb=1000 done=1", bv, wr_strobe, done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        beat(3'b000, 4'h1, 1'b1);
        beat(3'b000, 4'h2, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bv !== 16'h0000 || busy !== 1'b0 || in_ready !== 1'b0 || wr_strobe !== 4'b0000) begin
            errors++; $display("FAIL mid_reset got b=%h busy=%b rdy=%b strb=%b exp b=0000 busy=0 rdy=0 strb=0000", bv, busy, in_ready, wr_strobe);
        end
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_release got rdy=%b busy=%b done=%b exp 1 0 0", in_ready, busy, done);
        end
        tick(); tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || wr_strobe !== 4'b0000) begin
            errors++; $display("FAIL mid_nodone got done=%b busy=%b strb=%b exp 0 0 0000", done, busy, wr_strobe);
        end
        beat(3'b001, 4'h3, 1'b0);
        checks++;
        if (bv !== 16'h0030 || wr_strobe !== 4'b0010 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_idle_write got b=%h strb=%b busy=%b exp b=0030 strb=0010 busy=0", bv, wr_strobe, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clr_set();
        test_burst_stall();
        test_back_to_back();
        test_burst_ignores();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
